// File: rtl/lsu_req_buffer.sv
// lsu_req_buffer: in-order load/store request queue in front of a memory controller.
// The queue holds up to DEPTH requests and keeps at most one request outstanding.
// Each completion is a one-cycle rsp pulse.
//
// Ports:
//   clk, reset                  clock, asynchronous active-low reset
//   req_valid/req_ready         core request handshake; req_ready = count < DEPTH
//   req_write/addr/wdata        request payload
//   rsp_valid/rsp_write/data    completion pulse; rsp_data holds between pulses
//   mem_{read,write}_valid      request strobes to the controller
//   mem_{read,write}_address    request address (the same register drives both ports)
//   mem_write_data              write data
//   mem_{read,write}_ready      controller completion flags
//   mem_read_data               read return data
//   count                       queued, not-yet-issued entries
//   busy                        count != 0 or a request is in flight
module lsu_req_buffer #(
  parameter int unsigned ADDR_BITS = 8,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned DEPTH     = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic [ADDR_BITS-1:0]      req_addr,
  input  logic [DATA_BITS-1:0]      req_wdata,
  output logic                      rsp_valid,
  output logic                      rsp_write,
  output logic [DATA_BITS-1:0]      rsp_data,
  output logic                      mem_read_valid,
  output logic                      mem_write_valid,
  output logic [ADDR_BITS-1:0]      mem_read_address,
  output logic [ADDR_BITS-1:0]      mem_write_address,
  output logic [DATA_BITS-1:0]      mem_write_data,
  input  logic                      mem_read_ready,
  input  logic                      mem_write_ready,
  input  logic [DATA_BITS-1:0]      mem_read_data,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      busy
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] CountFull = (PtrW+1)'(DEPTH);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StWait    = 2'd1;
  localparam logic [1:0] StRelease = 2'd2;

  // Queue storage; entries need no reset because the pointers and count define validity.
  logic                 fifo_write_q [DEPTH];
  logic [ADDR_BITS-1:0] fifo_addr_q  [DEPTH];
  logic [DATA_BITS-1:0] fifo_wdata_q [DEPTH];

  logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]        count_q, count_d;
  logic [1:0]           state_q, state_d;

  logic                 cur_write_q;
  logic [ADDR_BITS-1:0] addr_q;
  logic [DATA_BITS-1:0] wdata_q;
  logic                 rd_valid_q, wr_valid_q;
  logic                 rsp_valid_q, rsp_write_q;
  logic [DATA_BITS-1:0] rsp_data_q;

  logic push, pop, match_ready, wait_done;

  // req_ready uses the pre-edge count, so a push while full is refused even when a pop
  // happens on the same edge.
  assign req_ready   = (count_q != CountFull);
  assign push        = req_valid && req_ready;
  assign pop         = (state_q == StIdle) && (count_q != '0);
  // Only the ready matching the outstanding request type counts.
  assign match_ready = cur_write_q ? mem_write_ready : mem_read_ready;
  assign wait_done   = (state_q == StWait) && match_ready;

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (pop) state_d = StWait;
      StWait:    if (match_ready) state_d = StRelease;
      StRelease: if (!match_ready) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_write_q[wr_ptr_q] <= req_write;
      fifo_addr_q[wr_ptr_q]  <= req_addr;
      fifo_wdata_q[wr_ptr_q] <= req_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= StIdle;
      cur_write_q <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rd_valid_q  <= 1'b0;
      wr_valid_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      // Response flags are single-cycle pulses unless set below.
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q    <= rd_ptr_q + 1'b1;
        cur_write_q <= fifo_write_q[rd_ptr_q];
        addr_q      <= fifo_addr_q[rd_ptr_q];
        wdata_q     <= fifo_wdata_q[rd_ptr_q];
        rd_valid_q  <= !fifo_write_q[rd_ptr_q];
        wr_valid_q  <= fifo_write_q[rd_ptr_q];
      end
      if (wait_done) begin
        rd_valid_q  <= 1'b0;
        wr_valid_q  <= 1'b0;
        rsp_valid_q <= 1'b1;
        rsp_write_q <= cur_write_q;
        if (!cur_write_q) begin
          rsp_data_q <= mem_read_data;
        end
      end
    end
  end

  assign rsp_valid         = rsp_valid_q;
  assign rsp_write         = rsp_write_q;
  assign rsp_data          = rsp_data_q;
  assign mem_read_valid    = rd_valid_q;
  assign mem_write_valid   = wr_valid_q;
  assign mem_read_address  = addr_q;
  assign mem_write_address = addr_q;
  assign mem_write_data    = wdata_q;
  assign count             = count_q;
  assign busy              = (count_q != '0) || (state_q != StIdle);

endmodule

// File: tb/tb_lsu_req_buffer.sv
// Bench for lsu_req_buffer: directed requests, a behavioural memory responder,
// and a response scoreboard checked by an independent monitor.
module tb_lsu_req_buffer;

  logic       clk, reset;
  logic       req_valid, req_ready, req_write;
  logic [7:0] req_addr, req_wdata;
  logic       rsp_valid, rsp_write;
  logic [7:0] rsp_data;
  logic       mem_read_valid, mem_write_valid;
  logic [7:0] mem_read_address, mem_write_address, mem_write_data;
  logic       mem_read_ready, mem_write_ready;
  logic [7:0] mem_read_data;
  logic [2:0] count;
  logic       busy;

  lsu_req_buffer #(.ADDR_BITS(8), .DATA_BITS(8), .DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_data(rsp_data),
    .mem_read_valid(mem_read_valid), .mem_write_valid(mem_write_valid),
    .mem_read_address(mem_read_address), .mem_write_address(mem_write_address),
    .mem_write_data(mem_write_data),
    .mem_read_ready(mem_read_ready), .mem_write_ready(mem_write_ready),
    .mem_read_data(mem_read_data),
    .count(count), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [8:0] sb[$];           // {is_write, expected read data}
  logic [7:0] ref_mem [256];

  // Responder controls.
  int  lat      = 3;
  int  hold     = 0;
  bit  stall    = 0;
  bit  rand_lat = 0;
  int  resp_st  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory model: samples strobes on the falling edge, answers after a latency,
  // keeps ready high until valid drops plus 'hold' extra cycles.
  initial begin : responder
    int         cnt;
    logic       w;
    logic [7:0] a, d;
    cnt = 0; w = 0; a = 0; d = 0;
    mem_read_ready = 0; mem_write_ready = 0; mem_read_data = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        resp_st = 0; mem_read_ready = 0; mem_write_ready = 0;
        continue;
      end
      case (resp_st)
        0: if (!stall && (mem_read_valid || mem_write_valid)) begin
          w = mem_write_valid;
          a = w ? mem_write_address : mem_read_address;
          d = mem_write_data;
          cnt = rand_lat ? int'($urandom_range(0, 4)) : lat;
          resp_st = 1;
        end
        1: begin
          check("valid_held", w ? {31'd0, mem_write_valid} : {31'd0, mem_read_valid}, 1);
          check("other_valid_low", w ? {31'd0, mem_read_valid} : {31'd0, mem_write_valid}, 0);
          check("addr_held", w ? mem_write_address : mem_read_address, a);
          if (w) check("wdata_held", mem_write_data, d);
          if (cnt == 0) begin
            if (w) begin
              ref_mem[a] = d;
              mem_write_ready = 1;
            end else begin
              mem_read_data  = ref_mem[a];
              mem_read_ready = 1;
            end
            resp_st = 2;
          end else cnt--;
        end
        2: begin
          check("valid_dropped", {30'd0, mem_read_valid, mem_write_valid}, 0);
          cnt = hold;
          resp_st = 3;
        end
        default: begin
          // Still in release: nothing new may issue.
          check("no_issue_in_release", {30'd0, mem_read_valid, mem_write_valid}, 0);
          check("busy_in_release", {31'd0, busy}, 1);
          if (cnt == 0) begin
            mem_read_ready = 0; mem_write_ready = 0;
            resp_st = 0;
          end else cnt--;
        end
      endcase
    end
  end

  // Monitor: pops an expectation for every response pulse.
  logic [8:0] exp_rsp;
  always @(negedge clk) begin
    if (reset && rsp_valid) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_rsp: got rsp_write=%0b data=%0h want none", rsp_write, rsp_data);
      end else begin
        exp_rsp = sb.pop_front();
        check("rsp_write", {31'd0, rsp_write}, {31'd0, exp_rsp[8]});
        if (!exp_rsp[8]) check("rsp_data", {24'd0, rsp_data}, {24'd0, exp_rsp[7:0]});
      end
    end
  end

  // Called on a falling edge; drives one request across the next rising edge.
  task automatic push(input logic w, input logic [7:0] a, input logic [7:0] wd,
                      input logic [7:0] exp_rd, input logic exp_acc);
    req_valid = 1; req_write = w; req_addr = a; req_wdata = wd;
    check("req_ready", {31'd0, req_ready}, {31'd0, exp_acc});
    if (exp_acc) sb.push_back({w, exp_rd});
    @(posedge clk);
    #1 req_valid = 0;
    @(negedge clk);
  endtask

  task automatic push_wait(input logic w, input logic [7:0] a, input logic [7:0] wd,
                           input logic [7:0] exp_rd);
    int n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      total++; bad++;
      $display("FAIL req_ready_timeout: got 0 want 1");
    end
    push(w, a, wd, exp_rd, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || sb.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= 200) begin
      bad++;
      $display("FAIL idle_timeout: got busy=%0b pending=%0d want 0/0", busy, sb.size());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    ref_mem[8'h10] = 8'hAB;
    ref_mem[8'h30] = 8'hC3;
    ref_mem[8'h50] = 8'h77;
    ref_mem[8'h51] = 8'h88;
    reset = 0; req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0;
    repeat (2) @(negedge clk);

    // Reset state.
    check("rst_req_ready", {31'd0, req_ready}, 1);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_count", {29'd0, count}, 0);
    check("rst_valids", {30'd0, mem_read_valid, mem_write_valid}, 0);
    check("rst_rsp", {30'd0, rsp_valid, rsp_write}, 0);
    check("rst_rsp_data", {24'd0, rsp_data}, 0);
    check("rst_addr", {16'd0, mem_read_address, mem_write_address}, 0);
    check("rst_wdata", {24'd0, mem_write_data}, 0);
    reset = 1;
    @(negedge clk);

    // Single read: issue one cycle after acceptance, never combinationally.
    lat = 3;
    push(0, 8'h10, 8'h00, 8'hAB, 1);
    check("rd_not_comb", {31'd0, mem_read_valid}, 0);
    check("rd_count_1", {29'd0, count}, 1);
    @(negedge clk);
    check("rd_issued", {31'd0, mem_read_valid}, 1);
    check("rd_addr", {24'd0, mem_read_address}, 32'h10);
    check("rd_count_0", {29'd0, count}, 0);
    wait_idle();

    // Single write, then read it back.
    push(1, 8'h20, 8'h5A, 8'h00, 1);
    @(negedge clk);
    check("wr_issued", {31'd0, mem_write_valid}, 1);
    check("wr_addr", {24'd0, mem_write_address}, 32'h20);
    check("wr_data", {24'd0, mem_write_data}, 32'h5A);
    wait_idle();
    push(0, 8'h20, 8'h00, 8'h5A, 1);
    wait_idle();
    check("rsp_data_hold", {24'd0, rsp_data}, 32'h5A);

    // Fill with memory stalled: one issued, four queued, sixth dropped.
    stall = 1;
    push(1, 8'h31, 8'h11, 8'h00, 1);
    push(0, 8'h31, 8'h00, 8'h11, 1);
    push(1, 8'h32, 8'h22, 8'h00, 1);
    push(0, 8'h30, 8'h00, 8'hC3, 1);
    push(0, 8'h32, 8'h00, 8'h22, 1);
    check("full_count", {29'd0, count}, 4);
    push(1, 8'h33, 8'h99, 8'h00, 0);
    check("full_count_after_drop", {29'd0, count}, 4);
    check("full_head_valid", {31'd0, mem_write_valid}, 1);
    check("full_head_addr", {24'd0, mem_write_address}, 32'h31);
    check("full_head_data", {24'd0, mem_write_data}, 32'h11);
    stall = 0;
    wait_idle();
    push(0, 8'h33, 8'h00, 8'h00, 1);   // dropped write must not have landed
    wait_idle();

    // Wrap: alternating write/read with random latency.
    rand_lat = 1;
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) push_wait(1, 8'h40 + 8'(i / 2), 8'h60 + 8'(i), 8'h00);
      else            push_wait(0, 8'h40 + 8'(i / 2), 8'h00, 8'h60 + 8'(i - 1));
    end
    wait_idle();
    check("wrap_count_0", {29'd0, count}, 0);
    rand_lat = 0;

    // Slow release: ready stays high 4 extra cycles; next request must wait.
    lat = 1; hold = 4;
    push(0, 8'h50, 8'h00, 8'h77, 1);
    push(0, 8'h51, 8'h00, 8'h88, 1);
    wait_idle();
    hold = 0;

    // Reset while waiting with two entries queued.
    lat = 20;
    push(0, 8'h60, 8'h00, 8'h00, 1);
    push(0, 8'h61, 8'h00, 8'h00, 1);
    push(0, 8'h62, 8'h00, 8'h00, 1);
    check("pre_rst_count", {29'd0, count}, 2);
    check("pre_rst_valid", {31'd0, mem_read_valid}, 1);
    reset = 0;
    #1;
    sb.delete();
    check("mid_rst_valids", {30'd0, mem_read_valid, mem_write_valid}, 0);
    check("mid_rst_count", {29'd0, count}, 0);
    check("mid_rst_busy", {31'd0, busy}, 0);
    check("mid_rst_rsp", {31'd0, rsp_valid}, 0);
    repeat (2) @(negedge clk);
    reset = 1;
    repeat (3) @(negedge clk);
    check("post_rst_idle", {31'd0, busy}, 0);
    lat = 2;
    push(0, 8'h10, 8'h00, 8'hAB, 1);
    wait_idle();
    check("final_sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
